// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: central hazard detection and stall/flush generation for
// the 5-stage WISC-S25 pipeline, plus arbitration of the single memory port
// between I-cache and D-cache fills.
// Optional build macro HAZARD_STATS_EN adds three 32-bit event counters.
//
// state  | meaning
// -------+------------------------------------------------------
// IDLE   | memory port free; misses are arbitrated here (D first)
// I_FILL | memory port owned by the I-cache fill
// D_FILL | memory port owned by the D-cache fill
module hazard_stall_ctrl #(
  parameter int FILL_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] ID_SrcReg1,
  input  logic [3:0] ID_SrcReg2,
  input  logic       ID_uses_rs1,
  input  logic       ID_uses_rs2,
  input  logic       ID_is_store,
  input  logic       ID_is_B,
  input  logic       ID_is_BR,
  input  logic       branch_taken,
  input  logic       ID_EX_MemRead,
  input  logic       ID_EX_RegWrite,
  input  logic [3:0] ID_EX_reg_rd,
  input  logic       ID_EX_sets_flags,
  input  logic       EX_MEM_MemRead,
  input  logic [3:0] EX_MEM_reg_rd,
  input  logic       icache_miss,
  input  logic       dcache_miss,
  input  logic       mem_fill_done,
  output logic       PC_stall,
  output logic       IF_ID_stall,
  output logic       IF_flush,
  output logic       ID_EX_flush,
  output logic       EX_MEM_stall,
  output logic       MEM_WB_flush,
  output logic       ifill_grant,
  output logic       dfill_grant,
  output logic       fill_timeout
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stat_data_stalls,
  output logic [31:0] stat_flushes,
  output logic [31:0] stat_fill_cycles
`endif
);

  localparam int CW = $clog2(FILL_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(FILL_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILL_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_FILL = 2'd1,
    D_FILL = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   fill_cnt;
  logic            timeout_q;

  logic load_use, flag_haz, br_haz, data_stall;
  logic freeze, ifetch_wait, branch_flush;
  logic in_fill;

  // Hazard detection; a register-0 destination never creates a dependency.
  always_comb begin
    load_use = ID_EX_MemRead & ID_EX_RegWrite & (ID_EX_reg_rd != 4'd0) &
               ((ID_uses_rs1 & (ID_SrcReg1 == ID_EX_reg_rd)) |
                (ID_uses_rs2 & (ID_SrcReg2 == ID_EX_reg_rd) & ~ID_is_store));
    flag_haz = ID_is_B & ID_EX_sets_flags;
    br_haz   = ID_is_BR & (ID_SrcReg1 != 4'd0) &
               ((ID_EX_RegWrite & (ID_EX_reg_rd == ID_SrcReg1)) |
                (EX_MEM_MemRead & (EX_MEM_reg_rd == ID_SrcReg1)));
    data_stall = load_use | flag_haz | br_haz;
  end

  // Fill arbiter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state arbitration and all pipeline control outputs.
  always_comb begin
    state_nxt    = state;
    freeze       = 1'b0;
    ifetch_wait  = 1'b0;
    branch_flush = 1'b0;
    in_fill      = 1'b0;
    PC_stall     = 1'b0;
    IF_ID_stall  = 1'b0;
    IF_flush     = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_stall = 1'b0;
    MEM_WB_flush = 1'b0;
    ifill_grant  = 1'b0;
    dfill_grant  = 1'b0;
    fill_timeout = 1'b0;

    case (state)
      IDLE: begin
        if (dcache_miss)      state_nxt = D_FILL;
        else if (icache_miss) state_nxt = I_FILL;
      end
      I_FILL, D_FILL: begin
        if (mem_fill_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    in_fill      = (state == I_FILL) | (state == D_FILL);
    freeze       = dcache_miss | (state == D_FILL);
    ifetch_wait  = (icache_miss | (state == I_FILL)) & ~freeze;
    branch_flush = branch_taken & ~data_stall & ~freeze & ~ifetch_wait;

    // Outputs are held low for as long as reset is asserted.
    if (rst_n) begin
      PC_stall     = data_stall | freeze | ifetch_wait;
      IF_ID_stall  = data_stall | freeze;
      // A stalled IF/ID must keep its instruction, so stall beats the NOP.
      IF_flush     = branch_flush | (ifetch_wait & ~data_stall);
      ID_EX_flush  = data_stall & ~freeze;
      EX_MEM_stall = freeze;
      MEM_WB_flush = freeze;
      ifill_grant  = (state == I_FILL);
      dfill_grant  = (state == D_FILL);
      fill_timeout = timeout_q;
    end
  end

  // Saturating fill-duration counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (!in_fill) begin
      fill_cnt <= '0;
    end else if (fill_cnt != CNT_MAX) begin
      fill_cnt <= fill_cnt + 1'b1;
      if (fill_cnt == CNT_LAST) timeout_q <= 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  // Free-running event counters; they wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_data_stalls <= '0;
      stat_flushes     <= '0;
      stat_fill_cycles <= '0;
    end else begin
      if (data_stall & ~freeze) stat_data_stalls <= stat_data_stalls + 32'd1;
      if (branch_flush)         stat_flushes     <= stat_flushes + 32'd1;
      if (in_fill)              stat_fill_cycles <= stat_fill_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (FILL_TIMEOUT overridden to 4).
// Observed vector bit order:
// {PC_stall, IF_ID_stall, IF_flush, ID_EX_flush, EX_MEM_stall, MEM_WB_flush,
//  ifill_grant, dfill_grant, fill_timeout}
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ID_SrcReg1, ID_SrcReg2, ID_EX_reg_rd, EX_MEM_reg_rd;
  logic       ID_uses_rs1, ID_uses_rs2, ID_is_store, ID_is_B, ID_is_BR;
  logic       branch_taken, ID_EX_MemRead, ID_EX_RegWrite, ID_EX_sets_flags;
  logic       EX_MEM_MemRead, icache_miss, dcache_miss, mem_fill_done;
  logic       PC_stall, IF_ID_stall, IF_flush, ID_EX_flush, EX_MEM_stall;
  logic       MEM_WB_flush, ifill_grant, dfill_grant, fill_timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.FILL_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_SrcReg1(ID_SrcReg1), .ID_SrcReg2(ID_SrcReg2),
    .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
    .ID_is_store(ID_is_store), .ID_is_B(ID_is_B), .ID_is_BR(ID_is_BR),
    .branch_taken(branch_taken),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
    .ID_EX_reg_rd(ID_EX_reg_rd), .ID_EX_sets_flags(ID_EX_sets_flags),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_reg_rd(EX_MEM_reg_rd),
    .icache_miss(icache_miss), .dcache_miss(dcache_miss),
    .mem_fill_done(mem_fill_done),
    .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall), .IF_flush(IF_flush),
    .ID_EX_flush(ID_EX_flush), .EX_MEM_stall(EX_MEM_stall),
    .MEM_WB_flush(MEM_WB_flush), .ifill_grant(ifill_grant),
    .dfill_grant(dfill_grant), .fill_timeout(fill_timeout)
  );

  wire [8:0] obs = {PC_stall, IF_ID_stall, IF_flush, ID_EX_flush, EX_MEM_stall,
                    MEM_WB_flush, ifill_grant, dfill_grant, fill_timeout};

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic clr();
    ID_SrcReg1 = 4'd0; ID_SrcReg2 = 4'd0; ID_EX_reg_rd = 4'd0; EX_MEM_reg_rd = 4'd0;
    ID_uses_rs1 = 1'b0; ID_uses_rs2 = 1'b0; ID_is_store = 1'b0; ID_is_B = 1'b0;
    ID_is_BR = 1'b0; branch_taken = 1'b0; ID_EX_MemRead = 1'b0; ID_EX_RegWrite = 1'b0;
    ID_EX_sets_flags = 1'b0; EX_MEM_MemRead = 1'b0;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_lw(input logic [3:0] rd);
    ID_EX_MemRead = 1'b1; ID_EX_RegWrite = 1'b1; ID_EX_reg_rd = rd;
  endtask

  initial begin
    clr();
    icache_miss = 1'b0; dcache_miss = 1'b0; mem_fill_done = 1'b0;
    rst_n = 1'b0;
    // Hazard-producing inputs during reset must not reach the outputs.
    ID_is_B = 1'b1; ID_EX_sets_flags = 1'b1; dcache_miss = 1'b1; icache_miss = 1'b1;
    #3;
    check("reset_forced_zero", obs, 9'b000000000);
    tick();
    check("reset_held_zero", obs, 9'b000000000);
    clr(); icache_miss = 1'b0; dcache_miss = 1'b0;
    #2 rst_n = 1'b1;
    tick(); settle();
    check("idle_quiet", obs, 9'b000000000);

    // Load-use on rs1
    clr(); set_lw(4'd5); ID_SrcReg1 = 4'd5; ID_uses_rs1 = 1'b1; settle();
    check("load_use_rs1", obs, 9'b110100000);
    clr(); set_lw(4'd0); ID_SrcReg1 = 4'd0; ID_uses_rs1 = 1'b1; settle();
    check("load_use_rd0", obs, 9'b000000000);
    clr(); set_lw(4'd5); ID_SrcReg1 = 4'd5; ID_uses_rs1 = 1'b0; settle();
    check("load_use_rs1_unused", obs, 9'b000000000);

    // Store-data exemption
    clr(); set_lw(4'd5); ID_is_store = 1'b1; ID_SrcReg2 = 4'd5; ID_uses_rs2 = 1'b1;
    ID_SrcReg1 = 4'd3; ID_uses_rs1 = 1'b1; settle();
    check("store_data_exempt", obs, 9'b000000000);
    ID_SrcReg1 = 4'd5; settle();
    check("store_base_stall", obs, 9'b110100000);
    ID_is_store = 1'b0; ID_SrcReg1 = 4'd3; settle();
    check("load_use_rs2", obs, 9'b110100000);

    // Flag hazard against a taken branch, then the re-resolved branch
    clr(); ID_is_B = 1'b1; ID_EX_sets_flags = 1'b1; branch_taken = 1'b1; settle();
    check("flag_haz_branch", obs, 9'b110100000);
    tick(); ID_EX_sets_flags = 1'b0; settle();
    check("branch_flush", obs, 9'b001000000);

    // BR target register hazards
    clr(); ID_is_BR = 1'b1; ID_SrcReg1 = 4'd7; ID_EX_RegWrite = 1'b1; ID_EX_reg_rd = 4'd7; settle();
    check("br_haz_ex", obs, 9'b110100000);
    clr(); ID_is_BR = 1'b1; ID_SrcReg1 = 4'd9; EX_MEM_MemRead = 1'b1; EX_MEM_reg_rd = 4'd9; settle();
    check("br_haz_mem_lw", obs, 9'b110100000);
    ID_SrcReg1 = 4'd0; EX_MEM_reg_rd = 4'd0; settle();
    check("br_haz_r0", obs, 9'b000000000);
    clr();

    // Simultaneous misses: D wins
    tick(); icache_miss = 1'b1; dcache_miss = 1'b1; settle();
    check("both_miss_idle", obs, 9'b110011000);
    tick(); settle();
    check("dfill_granted", obs, 9'b110011010);
    set_lw(4'd5); ID_SrcReg1 = 4'd5; ID_uses_rs1 = 1'b1; settle();
    check("freeze_over_stall", obs, 9'b110011010);
    clr();
    tick(); mem_fill_done = 1'b1; dcache_miss = 1'b0; settle();
    check("dfill_done_cycle", obs, 9'b110011010);
    tick(); mem_fill_done = 1'b0; settle();
    check("idle_ifetch_wait", obs, 9'b101000000);
    tick(); settle();
    check("ifill_granted", obs, 9'b101000100);
    set_lw(4'd5); ID_SrcReg1 = 4'd5; ID_uses_rs1 = 1'b1; settle();
    check("ifill_data_stall", obs, 9'b110100100);
    clr(); branch_taken = 1'b1; settle();
    check("ifill_branch_ignored", obs, 9'b101000100);
    clr();

    // Asynchronous reset in the middle of the I-cache fill
    tick(); rst_n = 1'b0; #1;
    check("async_reset_drop", obs, 9'b000000000);
    icache_miss = 1'b0; #1 rst_n = 1'b1;
    tick(); settle();
    check("after_reset_idle", obs, 9'b000000000);

    // Fill timeout
    tick(); dcache_miss = 1'b1; settle();
    check("timeout_miss_idle", obs, 9'b110011000);
    tick(); tick(); tick(); tick(); settle();
    check("timeout_not_yet", obs, 9'b110011010);
    tick(); settle();
    check("timeout_set", obs, 9'b110011011);
    tick(); tick(); settle();
    check("timeout_saturated", obs, 9'b110011011);
    mem_fill_done = 1'b1; dcache_miss = 1'b0;
    tick(); mem_fill_done = 1'b0; settle();
    check("timeout_sticky_idle", obs, 9'b000000001);
    tick(); settle();
    check("timeout_still_sticky", obs, 9'b000000001);
    rst_n = 1'b0; #1;
    check("timeout_reset", obs, 9'b000000000);
    #1 rst_n = 1'b1;
    tick(); settle();
    check("timeout_cleared", obs, 9'b000000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
